pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 16 +
 rtl/pipe_slot.sv | 74 +++++++
 rtl/pipe_stage_reg.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the pipeline stage register: reset PC, exception code
// width and the exception codes carried through the pipe.
package pipe_stage_reg_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int          EXC_W            = 5;

    typedef logic [EXC_W-1:0] exccode_t;

    localparam exccode_t EXC_INT  = 5'd0;
    localparam exccode_t EXC_ADEL = 5'd4;
    localparam exccode_t EXC_ADES = 5'd5;
    localparam exccode_t EXC_RI   = 5'd10;
    localparam exccode_t EXC_OV   = 5'd12;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: holds, loads a bubble, or captures its inputs each edge.
// Bubble load has priority over hold so a flush always clears the slot.
module pipe_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int          DATA_W   = 96,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              bubble_i,
    input  logic              valid_i,
    input  logic [31:0]       pc_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              exc_i,
    input  logic [EXC_W-1:0]  exccode_i,
    output logic              valid_o,
    output logic [31:0]       pc_o,
    output logic [DATA_W-1:0] data_o,
    output logic              exc_o,
    output logic [EXC_W-1:0]  exccode_o
);

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              exc_q, exc_d;
    logic [EXC_W-1:0]  exccode_q, exccode_d;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        data_d    = data_q;
        exc_d     = exc_q;
        exccode_d = exccode_q;
        if (bubble_i) begin
            valid_d   = 1'b0;
            pc_d      = PC_RESET;
            data_d    = '0;
            exc_d     = 1'b0;
            exccode_d = EXC_INT;
        end else if (!hold_i) begin
            valid_d   = valid_i;
            pc_d      = pc_i;
            data_d    = data_i;
            exc_d     = exc_i;
            exccode_d = exccode_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            pc_q      <= PC_RESET;
            data_q    <= '0;
            exc_q     <= 1'b0;
            exccode_q <= EXC_INT;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            data_q    <= data_d;
            exc_q     <= exc_d;
            exccode_q <= exccode_d;
        end
    end

    assign valid_o   = valid_q;
    assign pc_o      = pc_q;
    assign data_o    = data_q;
    assign exc_o     = exc_q;
    assign exccode_o = exccode_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: DEPTH slots in series with stall/flush, exception
// merge on entry, registered occupancy and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int          DATA_W   = 96,
    parameter int          DEPTH    = 1,
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_exc,
    input  logic [EXC_W-1:0]           in_exccode,
    input  logic                       loc_exc,
    input  logic [EXC_W-1:0]           loc_exccode,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_exc,
    output logic [EXC_W-1:0]           out_exccode,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                stall_cycles
);

    localparam int OCC_W = $clog2(DEPTH+1);

    // Entry value for slot 0; an invalid input always enters as a bubble.
    logic              m_valid;
    logic [31:0]       m_pc;
    logic [DATA_W-1:0] m_data;
    logic              m_exc;
    logic [EXC_W-1:0]  m_exccode;

    always_comb begin
        m_valid   = 1'b0;
        m_pc      = PC_RESET;
        m_data    = '0;
        m_exc     = 1'b0;
        m_exccode = EXC_INT;
        if (in_valid) begin
            m_valid = 1'b1;
            m_pc    = in_pc;
            m_data  = in_data;
            m_exc   = in_exc | loc_exc;
            // The older upstream exception wins over one raised here.
            if (in_exc)
                m_exccode = in_exccode;
            else if (loc_exc)
                m_exccode = loc_exccode;
        end
    end

    logic              sin_valid   [DEPTH];
    logic [31:0]       sin_pc      [DEPTH];
    logic [DATA_W-1:0] sin_data    [DEPTH];
    logic              sin_exc     [DEPTH];
    logic [EXC_W-1:0]  sin_exccode [DEPTH];

    logic              slot_valid   [DEPTH];
    logic [31:0]       slot_pc      [DEPTH];
    logic [DATA_W-1:0] slot_data    [DEPTH];
    logic              slot_exc     [DEPTH];
    logic [EXC_W-1:0]  slot_exccode [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        if (k == 0) begin : g_head
            assign sin_valid[k]   = m_valid;
            assign sin_pc[k]      = m_pc;
            assign sin_data[k]    = m_data;
            assign sin_exc[k]     = m_exc;
            assign sin_exccode[k] = m_exccode;
        end else begin : g_chain
            assign sin_valid[k]   = slot_valid[k-1];
            assign sin_pc[k]      = slot_pc[k-1];
            assign sin_data[k]    = slot_data[k-1];
            assign sin_exc[k]     = slot_exc[k-1];
            assign sin_exccode[k] = slot_exccode[k-1];
        end

        pipe_slot #(
            .DATA_W   (DATA_W),
            .PC_RESET (PC_RESET)
        ) u_slot (
            .clk_i     (clk),
            .rst_i     (reset),
            .hold_i    (stall),
            .bubble_i  (flush),
            .valid_i   (sin_valid[k]),
            .pc_i      (sin_pc[k]),
            .data_i    (sin_data[k]),
            .exc_i     (sin_exc[k]),
            .exccode_i (sin_exccode[k]),
            .valid_o   (slot_valid[k]),
            .pc_o      (slot_pc[k]),
            .data_o    (slot_data[k]),
            .exc_o     (slot_exc[k]),
            .exccode_o (slot_exccode[k])
        );
    end

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] occ_shift;
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    // Occupancy after an advance: the entry plus every slot but the last.
    always_comb begin
        occ_shift = OCC_W'(m_valid);
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (slot_valid[k])
                occ_shift = occ_shift + OCC_W'(1);
        end
        if (flush)
            occ_d = '0;
        else if (stall)
            occ_d = occ_q;
        else
            occ_d = occ_shift;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            occ_q       <= occ_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid    = slot_valid[DEPTH-1];
    assign out_pc       = slot_pc[DEPTH-1];
    assign out_data     = slot_data[DEPTH-1];
    assign out_exc      = slot_exc[DEPTH-1];
    assign out_exccode  = slot_exccode[DEPTH-1];
    assign occupancy    = occ_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DEPTH=1 vector table, plus DEPTH=2/3 sequences for
// latency, stall hold, async reset and stall counter saturation.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [95:0] in_data;
    logic        in_exc;
    logic [4:0]  in_exccode;
    logic        loc_exc;
    logic [4:0]  loc_exccode;

    logic        v1, v2, v3;
    logic [31:0] pc1, pc2, pc3;
    logic [95:0] d1, d2, d3;
    logic        e1, e2, e3;
    logic [4:0]  c1, c2, c3;
    logic [0:0]  occ1;
    logic [1:0]  occ2, occ3;
    logic [15:0] sc1, sc2, sc3;

    int n_vec  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data),
        .in_exc(in_exc), .in_exccode(in_exccode),
        .loc_exc(loc_exc), .loc_exccode(loc_exccode),
        .out_valid(v1), .out_pc(pc1), .out_data(d1), .out_exc(e1),
        .out_exccode(c1), .occupancy(occ1), .stall_cycles(sc1)
    );

    pipe_stage_reg #(.DATA_W(96), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data),
        .in_exc(in_exc), .in_exccode(in_exccode),
        .loc_exc(loc_exc), .loc_exccode(loc_exccode),
        .out_valid(v2), .out_pc(pc2), .out_data(d2), .out_exc(e2),
        .out_exccode(c2), .occupancy(occ2), .stall_cycles(sc2)
    );

    pipe_stage_reg #(.DATA_W(96), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data),
        .in_exc(in_exc), .in_exccode(in_exccode),
        .loc_exc(loc_exc), .loc_exccode(loc_exccode),
        .out_valid(v3), .out_pc(pc3), .out_data(d3), .out_exc(e3),
        .out_exccode(c3), .occupancy(occ3), .stall_cycles(sc3)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        vld;
        logic [31:0] pc;
        logic [95:0] data;
        logic        iexc;
        logic [4:0]  icode;
        logic        lexc;
        logic [4:0]  lcode;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [95:0] e_data;
        logic        e_exc;
        logic [4:0]  e_code;
        logic        e_occ;
        logic [15:0] e_stall;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_pc       = 32'h0;
        in_data     = '0;
        in_exc      = 1'b0;
        in_exccode  = 5'd0;
        loc_exc     = 1'b0;
        loc_exccode = 5'd0;
    endtask

    // Called at posedge+1: async assert mid-cycle, release just after the next edge.
    task automatic do_reset();
        idle_inputs();
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        // stall, flush, vld, pc, data, iexc, icode, lexc, lcode |
        // e_vld, e_pc, e_data, e_exc, e_code, e_occ, e_stall
        vec[0]  = '{0, 0, 1, 32'h3000, 96'hA1, 0, 5'd0, 0, 5'd0,
                    1, 32'h3000, 96'hA1, 0, 5'd0, 1, 16'd0};
        vec[1]  = '{0, 0, 1, 32'h3004, 96'hB2, 1, 5'd4, 1, 5'd12,
                    1, 32'h3004, 96'hB2, 1, 5'd4, 1, 16'd0};
        vec[2]  = '{0, 0, 1, 32'h3008, 96'hC3, 0, 5'd4, 1, 5'd12,
                    1, 32'h3008, 96'hC3, 1, 5'd12, 1, 16'd0};
        vec[3]  = '{0, 0, 0, 32'h1234, 96'hFF, 1, 5'd4, 1, 5'd12,
                    0, 32'h3000, 96'h0, 0, 5'd0, 0, 16'd0};
        vec[4]  = '{0, 0, 1, 32'h300C, 96'hDEAD_BEEF_0123_4567_89AB_CDEF, 1, 5'd10, 0, 5'd0,
                    1, 32'h300C, 96'hDEAD_BEEF_0123_4567_89AB_CDEF, 1, 5'd10, 1, 16'd0};
        vec[5]  = '{1, 0, 1, 32'h4000, 96'h55, 0, 5'd0, 1, 5'd5,
                    1, 32'h300C, 96'hDEAD_BEEF_0123_4567_89AB_CDEF, 1, 5'd10, 1, 16'd1};
        vec[6]  = '{1, 1, 1, 32'h4004, 96'h66, 0, 5'd0, 0, 5'd0,
                    0, 32'h3000, 96'h0, 0, 5'd0, 0, 16'd1};
        vec[7]  = '{0, 1, 1, 32'h4008, 96'h77, 1, 5'd4, 0, 5'd0,
                    0, 32'h3000, 96'h0, 0, 5'd0, 0, 16'd1};
        vec[8]  = '{0, 0, 1, 32'h3010, {96{1'b1}}, 0, 5'd4, 1, 5'd5,
                    1, 32'h3010, {96{1'b1}}, 1, 5'd5, 1, 16'd1};
        vec[9]  = '{0, 0, 1, 32'h3014, 96'h0, 1, 5'd0, 1, 5'd12,
                    1, 32'h3014, 96'h0, 1, 5'd0, 1, 16'd1};
        vec[10] = '{1, 0, 0, 32'h0, 96'h0, 0, 5'd0, 0, 5'd0,
                    1, 32'h3014, 96'h0, 1, 5'd0, 1, 16'd2};
        vec[11] = '{0, 0, 0, 32'h0, 96'h0, 0, 5'd0, 0, 5'd0,
                    0, 32'h3000, 96'h0, 0, 5'd0, 0, 16'd2};

        reset = 1'b0;
        idle_inputs();
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 128'(v3), 128'h0);
        chk("rst_pc", 128'(pc3), 128'h3000);
        chk("rst_data", 128'(d3), 128'h0);
        chk("rst_exc", 128'({e3, c3}), 128'h0);
        chk("rst_occ", 128'(occ3), 128'h0);
        chk("rst_stall_cnt", 128'(sc3), 128'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // DEPTH=1 vector table
        for (int i = 0; i < NVEC; i++) begin
            stall       = vec[i].stall;
            flush       = vec[i].flush;
            in_valid    = vec[i].vld;
            in_pc       = vec[i].pc;
            in_data     = vec[i].data;
            in_exc      = vec[i].iexc;
            in_exccode  = vec[i].icode;
            loc_exc     = vec[i].lexc;
            loc_exccode = vec[i].lcode;
            step();
            chk($sformatf("vec%0d_valid", i), 128'(v1), 128'(vec[i].e_vld));
            chk($sformatf("vec%0d_pc", i), 128'(pc1), 128'(vec[i].e_pc));
            chk($sformatf("vec%0d_data", i), 128'(d1), 128'(vec[i].e_data));
            chk($sformatf("vec%0d_exc", i), 128'(e1), 128'(vec[i].e_exc));
            chk($sformatf("vec%0d_code", i), 128'(c1), 128'(vec[i].e_code));
            chk($sformatf("vec%0d_occ", i), 128'(occ1), 128'(vec[i].e_occ));
            chk($sformatf("vec%0d_stall_cnt", i), 128'(sc1), 128'(vec[i].e_stall));
        end

        // DEPTH=3 latency and ordering
        do_reset();
        in_valid = 1'b1; in_pc = 32'h3000; in_data = 96'h100; step();
        in_pc = 32'h3004; in_data = 96'h104; step();
        in_pc = 32'h3008; in_data = 96'h108; step();
        chk("lat_valid", 128'(v3), 128'h1);
        chk("lat_pc0", 128'(pc3), 128'h3000);
        chk("lat_data0", 128'(d3), 128'h100);
        chk("lat_occ3", 128'(occ3), 128'h3);
        in_valid = 1'b0; step();
        chk("lat_pc1", 128'(pc3), 128'h3004);
        chk("lat_occ2", 128'(occ3), 128'h2);
        step();
        chk("lat_pc2", 128'(pc3), 128'h3008);
        chk("lat_occ1", 128'(occ3), 128'h1);

        // DEPTH=3 full, async reset between edges
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h3020 + 32'(4 * i);
            step();
        end
        chk("full_occ", 128'(occ3), 128'h3);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 128'(v3), 128'h0);
        chk("async_pc", 128'(pc3), 128'h3000);
        chk("async_data", 128'(d3), 128'h0);
        chk("async_occ", 128'(occ3), 128'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        step();
        chk("post_rst_empty", 128'(v3), 128'h0);

        // DEPTH=2 stall hold and release order
        do_reset();
        in_valid = 1'b1; in_pc = 32'h3100; step();
        in_pc = 32'h3104; step();
        chk("stall_pre_pc", 128'(pc2), 128'h3100);
        chk("stall_pre_occ", 128'(occ2), 128'h2);
        in_valid = 1'b0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("stall_hold%0d_pc", i), 128'(pc2), 128'h3100);
            chk($sformatf("stall_hold%0d_occ", i), 128'(occ2), 128'h2);
        end
        chk("stall_cnt4", 128'(sc2), 128'h4);
        stall = 1'b0; step();
        chk("release_pc1", 128'(pc2), 128'h3104);
        chk("release_occ1", 128'(occ2), 128'h1);
        step();
        chk("release_empty", 128'(v2), 128'h0);
        chk("release_cnt", 128'(sc2), 128'h4);

        // stall counter saturation
        do_reset();
        stall = 1'b1;
        repeat (65534) step();
        chk("sat_fffe", 128'(sc1), 128'hFFFE);
        repeat (6) step();
        chk("sat_ffff", 128'(sc1), 128'hFFFF);
        stall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
